// File: rtl/fifo_pkg.sv
`default_nettype none
// =============================================================================
// fifo_pkg : shared types, defaults and level-compare helpers for FIFO blocks
// Rev 1.0
// =============================================================================
package fifo_pkg;

   localparam int FIFO_DATA_WIDTH_DEF   = 68;
   localparam int FIFO_LOGDEPTH_DEF     = 7;
   localparam int FIFO_AFULL_MARGIN_DEF = 4;
   localparam int FIFO_AEMPTY_LEVEL_DEF = 4;

   typedef struct packed {
      logic overflow;
      logic underflow;
   } fifo_err_t;

   function automatic logic level_ge(input int cnt, input int lvl);
      return (cnt >= lvl);
   endfunction

   function automatic logic level_le(input int cnt, input int lvl);
      return (cnt <= lvl);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_sync_if.sv
`default_nettype none
// =============================================================================
// fifo_sync_if : handshake, data and status bundle for fifo_sync
// Rev 1.0
// =============================================================================
interface fifo_sync_if #(
   parameter int DATA_WIDTH = 68,
   parameter int LOGDEPTH   = 7
);

   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  almost_full;
   logic                  empty;
   logic                  almost_empty;
   logic [LOGDEPTH:0]     count;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr;

   modport master (
      output flush, wr_en, din, rd_en, err_clr,
      input  dout, full, almost_full, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, din, rd_en, err_clr,
      output dout, full, almost_full, empty, almost_empty, count, overflow, underflow
   );

endinterface
`default_nettype wire

// File: rtl/fifo_sync_ram.sv
`default_nettype none
// =============================================================================
// fifo_sync_ram : simple dual-port RAM, one clock, registered read, no reset
// Rev 1.0
// =============================================================================
module fifo_sync_ram #(
   parameter int DATA_WIDTH = 68,
   parameter int LOGDEPTH   = 7
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [LOGDEPTH-1:0]   waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [LOGDEPTH-1:0]   raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   localparam int DEPTH = 2**LOGDEPTH;

   logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fifo_sync.sv
`default_nettype none
// =============================================================================
// fifo_sync : single-clock FIFO with count, level/error flags and flush.
// FIFO_SYNC_FWFT_EN selects first-word-fall-through reads.        Rev 1.0
// =============================================================================
module fifo_sync
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = FIFO_DATA_WIDTH_DEF,
   parameter int LOGDEPTH     = FIFO_LOGDEPTH_DEF,
   parameter int AFULL_LEVEL  = (2**LOGDEPTH) - FIFO_AFULL_MARGIN_DEF,
   parameter int AEMPTY_LEVEL = FIFO_AEMPTY_LEVEL_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   fifo_sync_if.slave bus
);

   localparam int             DEPTH      = 2**LOGDEPTH;
   localparam int             CW         = LOGDEPTH + 1;
   localparam logic [CW-1:0]  DEPTH_C    = CW'(DEPTH);
   localparam logic           AFULL_RST  = level_ge(0, AFULL_LEVEL);
   localparam logic           AEMPTY_RST = level_le(0, AEMPTY_LEVEL);

   logic [LOGDEPTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [LOGDEPTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   fifo_err_t             err_q, err_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  aempty_q, aempty_d;

   logic                  wr_acc;
   logic                  rd_acc;
   logic                  ram_re;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign wr_acc = bus.wr_en && !full_q;
   assign rd_acc = bus.rd_en && !empty_q;

   fifo_sync_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOGDEPTH   (LOGDEPTH)
   ) u_ram (
      .clk     (clk),
      .we_i    (wr_acc && !bus.flush),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.din),
      .re_i    (ram_re),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

`ifdef FIFO_SYNC_FWFT_EN
   // The RAM output register doubles as the head-word prefetch stage.
   logic          valid_q, valid_d;
   logic [CW-1:0] ram_cnt;

   assign ram_cnt = count_q - CW'(valid_q);
   assign ram_re  = (ram_cnt != '0) && (!valid_q || rd_acc);

   always_comb begin
      valid_d = valid_q;
      if (ram_re) begin
         valid_d = 1'b1;
      end else if (rd_acc) begin
         valid_d = 1'b0;
      end
      if (bus.flush) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   assign empty_d  = !valid_d;
   assign bus.dout = valid_q ? ram_rdata : '0;
`else
   logic                  rd_pend_q;
   logic [DATA_WIDTH-1:0] dout_q;

   assign ram_re = rd_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend_q <= 1'b0;
         dout_q    <= '0;
      end else if (bus.flush) begin
         rd_pend_q <= 1'b0;
         dout_q    <= '0;
      end else begin
         rd_pend_q <= rd_acc;
         if (rd_pend_q) begin
            dout_q <= ram_rdata;
         end
      end
   end

   assign empty_d  = (count_d == '0);
   assign bus.dout = dout_q;
`endif

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;

      // A fresh error in the same cycle as err_clr wins.
      if (bus.err_clr) begin
         err_d = '0;
      end
      if (bus.wr_en && full_q) begin
         err_d.overflow = 1'b1;
      end
      if (bus.rd_en && empty_q) begin
         err_d.underflow = 1'b1;
      end

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + LOGDEPTH'(1);
      end
      if (ram_re) begin
         rd_ptr_d = rd_ptr_q + LOGDEPTH'(1);
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         err_d    = '0;
      end
   end

   assign full_d   = (count_d == DEPTH_C);
   assign afull_d  = level_ge(int'(count_d), AFULL_LEVEL);
   assign aempty_d = level_le(int'(count_d), AEMPTY_LEVEL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= AFULL_RST;
         aempty_q <= AEMPTY_RST;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         aempty_q <= aempty_d;
      end
   end

   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.overflow     = err_q.overflow;
   assign bus.underflow    = err_q.underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// tb_fifo_sync : directed and randomised checks of fifo_sync against a queue model.
module tb_fifo_sync;

   localparam int DW    = 8;
   localparam int LD    = 3;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   fifo_sync_if #(.DATA_WIDTH(DW), .LOGDEPTH(LD)) bus ();

   fifo_sync #(
      .DATA_WIDTH   (DW),
      .LOGDEPTH     (LD),
      .AFULL_LEVEL  (AF),
      .AEMPTY_LEVEL (AE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: contents queue, sticky errors, dout with one-edge read latency.
   logic [DW-1:0] mq[$];
   logic          m_ovf, m_udf, m_pend;
   logic [DW-1:0] m_pdata, m_dout;

   task automatic model_reset();
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      m_pend  = 1'b0;
      m_pdata = '0;
      m_dout  = '0;
   endtask

   function automatic logic [17:0] exp_vec();
      int n;
      n = mq.size();
      return {4'(n), 1'(n == DEPTH), 1'(n == 0), 1'(n >= AF), 1'(n <= AE), m_ovf, m_udf, m_dout};
   endfunction

   function automatic logic [17:0] obs_vec();
      return {bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
              bus.overflow, bus.underflow, bus.dout};
   endfunction

   task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic clr, input logic fl);
      int            n;
      logic [DW-1:0] nd;
      bus.wr_en   = wr;
      bus.din     = d;
      bus.rd_en   = rd;
      bus.err_clr = clr;
      bus.flush   = fl;
      @(posedge clk);
      n  = mq.size();
      nd = m_pend ? m_pdata : m_dout;
      m_pend = 1'b0;
      if (fl) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         nd    = '0;
      end else begin
         if (clr) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
         end
         if (wr && n == DEPTH) m_ovf = 1'b1;
         if (rd && n == 0)     m_udf = 1'b1;
         if (rd && n != 0) begin
            m_pdata = mq.pop_front();
            m_pend  = 1'b1;
         end
         if (wr && n != DEPTH) mq.push_back(d);
      end
      m_dout = nd;
      #1;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.err_clr = 1'b0;
      bus.flush   = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      #12;
      n_cmp++;
      if (obs_vec() !== 18'h0_a00 >> 0 && obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL reset_state: got %h want %h", obs_vec(), exp_vec());
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL pre_reset_state: got %h want %h", obs_vec(), exp_vec());
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_bad++;
         $display("FAIL async_reset: got %h want %h", obs_vec(), exp_vec());
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      logic exp_af, exp_full;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
         exp_af   = (i + 1 >= AF);
         exp_full = (i == 7);
         n_cmp++;
         if (bus.almost_full !== exp_af || bus.full !== exp_full) begin
            n_bad++;
            $display("FAIL fill_flags[%0d]: got af=%b full=%b want af=%b full=%b",
                     i, bus.almost_full, bus.full, exp_af, exp_full);
         end
      end
      cycle(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.overflow !== 1'b1 || bus.count !== 4'd8) begin
         n_bad++;
         $display("FAIL overflow: got ovf=%b count=%0d want ovf=1 count=8", bus.overflow, bus.count);
      end
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, '0, (i < 8), 1'b0, 1'b0);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i >= 1) begin
            n_cmp++;
            if (bus.dout !== 8'h10 + 8'(i - 1)) begin
               n_bad++;
               $display("FAIL drain_order[%0d]: got %h want %h", i, bus.dout, 8'h10 + 8'(i - 1));
            end
         end
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_simul();
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0, 1'b0);
         n_cmp++;
         if (bus.count !== 4'd3 || obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL simul[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, '0, (i < 3), 1'b0, 1'b0);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL simul_drain[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_underflow();
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (bus.underflow !== 1'b1 || bus.count !== 4'd0) begin
         n_bad++;
         $display("FAIL underflow: got udf=%b count=%0d want udf=1 count=0", bus.underflow, bus.count);
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (bus.underflow !== 1'b0) begin
         n_bad++;
         $display("FAIL err_clr: got udf=%b want 0", bus.underflow);
      end
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (bus.underflow !== 1'b1) begin
         n_bad++;
         $display("FAIL clr_vs_new_err: got udf=%b want 1", bus.underflow);
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.count !== 4'd4 || bus.overflow !== 1'b1 || bus.dout !== 8'h53) begin
         n_bad++;
         $display("FAIL pre_flush: got count=%0d ovf=%b dout=%h want 4 1 53",
                  bus.count, bus.overflow, bus.dout);
      end
      cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (obs_vec() !== exp_vec() || bus.count !== 4'd0 || bus.empty !== 1'b1) begin
         n_bad++;
         $display("FAIL flush: got %h want %h", obs_vec(), exp_vec());
      end
      cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.dout !== 8'h5A || bus.count !== 4'd0) begin
         n_bad++;
         $display("FAIL post_flush: got dout=%h count=%0d want 5a 0", bus.dout, bus.count);
      end
   endtask

   task automatic test_random();
      logic wr, rd, clr, fl;
      int   wbias;
      for (int i = 0; i < 400; i++) begin
         wbias = ((i / 50) % 2 == 0) ? 75 : 30;
         wr  = ($urandom_range(0, 99) < wbias);
         rd  = ($urandom_range(0, 99) < 100 - wbias);
         clr = ($urandom_range(0, 99) < 6);
         fl  = ($urandom_range(0, 99) < 2);
         cycle(wr, 8'($urandom), rd, clr, fl);
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL random[%0d]: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_fwft();
      logic [DW-1:0] exp_d;
      #12;
      n_cmp++;
      if (bus.empty !== 1'b1 || bus.count !== 4'd0 || bus.dout !== 8'h00) begin
         n_bad++;
         $display("FAIL fwft_reset: got empty=%b count=%0d dout=%h", bus.empty, bus.count, bus.dout);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b1;
      bus.din   = 8'hA5;
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      n_cmp++;
      if (bus.empty !== 1'b1 || bus.count !== 4'd1) begin
         n_bad++;
         $display("FAIL fwft_edge_n: got empty=%b count=%0d want 1 1", bus.empty, bus.count);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.empty !== 1'b0 || bus.dout !== 8'hA5) begin
         n_bad++;
         $display("FAIL fwft_edge_n1: got empty=%b dout=%h want 0 a5", bus.empty, bus.dout);
      end
      bus.rd_en = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      n_cmp++;
      if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin
         n_bad++;
         $display("FAIL fwft_pop: got empty=%b count=%0d want 1 0", bus.empty, bus.count);
      end
      for (int i = 0; i < 3; i++) begin
         bus.wr_en = 1'b1;
         bus.din   = 8'hB1 + 8'(i);
         @(posedge clk);
         #1;
      end
      bus.wr_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_d = 8'hB1 + 8'(i);
         n_cmp++;
         if ((i < 3) && (bus.empty !== 1'b0 || bus.dout !== exp_d || bus.count !== 4'(3 - i))) begin
            n_bad++;
            $display("FAIL fwft_head[%0d]: got empty=%b dout=%h count=%0d want 0 %h %0d",
                     i, bus.empty, bus.dout, bus.count, exp_d, 3 - i);
         end else if ((i == 3) && bus.empty !== 1'b1) begin
            n_bad++;
            $display("FAIL fwft_final_empty: got %b want 1", bus.empty);
         end
         bus.rd_en = (i < 3);
         @(posedge clk);
         #1;
         bus.rd_en = 1'b0;
      end
   endtask

   initial begin
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.din     = '0;
      bus.err_clr = 1'b0;
      bus.flush   = 1'b0;
`ifdef FIFO_SYNC_FWFT_EN
      test_fwft();
`else
      test_reset();
      test_fill();
      test_simul();
      test_underflow();
      test_flush();
      test_random();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
